// File: rtl/beat_note_sequencer_pkg.sv
// Shared types and song-ROM field layout for the beat note sequencer and the ROM generator.
// Each ROM word is {note, dur}; dur sits in the low bits and note directly above it.
package beat_note_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_ROM,
        PLAY,
        PAUSE,
        DONE
    } seq_state_t;

    localparam int DEF_ADDR_W = 6;
    localparam int DEF_NOTE_W = 5;
    localparam int DEF_DUR_W  = 4;

    localparam int NOTE_REST  = 0;
    localparam int DUR_LSB    = 0;

    function automatic int note_lsb(input int dur_w);
        return DUR_LSB + dur_w;
    endfunction

endpackage

// File: rtl/beat_down_counter.sv
// Per-entry beat counter: load a duration (0 plays as 1 beat) and count beat ticks down.
// One-cycle update; done is high while exactly one beat remains, so the next tick ends the entry.
module beat_down_counter #(
    parameter int DUR_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [DUR_W-1:0] load_val,
    input  logic             tick,
    output logic             done
);

    logic [DUR_W-1:0] cnt_q;
    logic [DUR_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = (load_val == '0) ? DUR_W'(1) : load_val;
        end else if (tick && (cnt_q != '0)) begin
            cnt_d = cnt_q - DUR_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == DUR_W'(1));

endmodule

// File: rtl/beat_note_sequencer.sv
// Walks a song ROM of {note, dur} entries, advancing one entry per dur beat ticks.
// play rise -> note_start in 3 clocks; entry end -> next note_start 2 clocks after the tick; play=0 pauses.
module beat_note_sequencer
    import beat_note_sequencer_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NOTE_W   = DEF_NOTE_W,
    parameter int DUR_W    = DEF_DUR_W,
    parameter int SONG_LEN = 48,
    parameter int LOOP     = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    play,
    input  logic                    stop,
    input  logic                    beat_tick,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [NOTE_W+DUR_W-1:0] rom_data,
    output logic [NOTE_W-1:0]       note,
    output logic                    note_on,
    output logic                    note_start,
    output logic                    song_done,
    output logic                    busy
);

    localparam int NOTE_LSB = note_lsb(DUR_W);

    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic              note_on_q, note_on_d;
    logic              note_start_q, note_start_d;
    logic              song_done_q, song_done_d;
    logic              busy_q, busy_d;

    logic [NOTE_W-1:0] rom_note;
    logic [DUR_W-1:0]  rom_dur;
    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_last;
    logic              last_entry;

    assign rom_note   = rom_data[NOTE_LSB +: NOTE_W];
    assign rom_dur    = rom_data[DUR_LSB +: DUR_W];
    assign last_entry = (ptr_q == ADDR_W'(SONG_LEN - 1));

    beat_down_counter #(
        .DUR_W (DUR_W)
    ) u_beat_cnt (
        .clock    (clock),
        .reset    (reset),
        .clear    (stop),
        .load     (cnt_load),
        .load_val (rom_dur),
        .tick     (cnt_dec),
        .done     (cnt_last)
    );

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        note_d       = note_q;
        note_on_d    = note_on_q;
        note_start_d = 1'b0;
        song_done_d  = 1'b0;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;

        case (state_q)
            IDLE: begin
                if (play) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = WAIT_ROM;
            end
            WAIT_ROM: begin
                note_d       = rom_note;
                note_on_d    = (rom_note != NOTE_W'(NOTE_REST));
                note_start_d = 1'b1;
                cnt_load     = 1'b1;
                state_d      = PLAY;
            end
            PLAY: begin
                // Pausing wins over a coincident tick; that tick is simply lost.
                if (!play) begin
                    note_on_d = 1'b0;
                    state_d   = PAUSE;
                end else if (beat_tick) begin
                    cnt_dec = 1'b1;
                    if (cnt_last) begin
                        note_on_d = 1'b0;
                        if (last_entry) begin
                            song_done_d = 1'b1;
                            if (LOOP != 0) begin
                                ptr_d   = '0;
                                state_d = FETCH;
                            end else begin
                                state_d = DONE;
                            end
                        end else begin
                            ptr_d   = ptr_q + ADDR_W'(1);
                            state_d = FETCH;
                        end
                    end
                end
            end
            PAUSE: begin
                note_on_d = 1'b0;
                if (play) begin
                    note_on_d = (note_q != NOTE_W'(NOTE_REST));
                    state_d   = PLAY;
                end
            end
            DONE: begin
                note_on_d = 1'b0;
                if (!play) begin
                    ptr_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // stop rewinds exactly like reset and overrides whatever the state logic chose.
        if (stop) begin
            state_d      = IDLE;
            ptr_d        = '0;
            note_d       = '0;
            note_on_d    = 1'b0;
            note_start_d = 1'b0;
            song_done_d  = 1'b0;
            cnt_dec      = 1'b0;
            cnt_load     = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            note_q       <= '0;
            note_on_q    <= 1'b0;
            note_start_q <= 1'b0;
            song_done_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            note_q       <= note_d;
            note_on_q    <= note_on_d;
            note_start_q <= note_start_d;
            song_done_q  <= song_done_d;
            busy_q       <= busy_d;
        end
    end

    assign rom_addr   = ptr_q;
    assign note       = note_q;
    assign note_on    = note_on_q;
    assign note_start = note_start_q;
    assign song_done  = song_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_beat_note_sequencer.sv
// Bench for beat_note_sequencer: a stop-at-end instance (3 entries) and a looping instance (2 entries)
// driven by directed and random songs, checked against an entry-list model of the song.
module tb_beat_note_sequencer;

    logic       clock;
    logic       reset;
    logic       play_a, play_b;
    logic       stop;
    logic       beat_tick;
    logic [5:0] rom_addr_a, rom_addr_b;
    logic [8:0] rom_data_a, rom_data_b;
    logic [4:0] note_a, note_b;
    logic       note_on_a, note_on_b;
    logic       note_start_a, note_start_b;
    logic       song_done_a, song_done_b;
    logic       busy_a, busy_b;

    logic [8:0] rom_a [64];
    logic [8:0] rom_b [64];

    int total = 0;
    int bad   = 0;
    int starts = 0;
    int dones  = 0;
    bit sel = 1'b0;

    logic [4:0] o_note;
    logic [5:0] o_addr;
    logic       o_on, o_start, o_done, o_busy;

    beat_note_sequencer #(
        .ADDR_W(6), .NOTE_W(5), .DUR_W(4), .SONG_LEN(3), .LOOP(0)
    ) dut_a (
        .clock(clock), .reset(reset), .play(play_a), .stop(stop), .beat_tick(beat_tick),
        .rom_addr(rom_addr_a), .rom_data(rom_data_a), .note(note_a), .note_on(note_on_a),
        .note_start(note_start_a), .song_done(song_done_a), .busy(busy_a)
    );

    beat_note_sequencer #(
        .ADDR_W(6), .NOTE_W(5), .DUR_W(4), .SONG_LEN(2), .LOOP(1)
    ) dut_b (
        .clock(clock), .reset(reset), .play(play_b), .stop(stop), .beat_tick(beat_tick),
        .rom_addr(rom_addr_b), .rom_data(rom_data_b), .note(note_b), .note_on(note_on_b),
        .note_start(note_start_b), .song_done(song_done_b), .busy(busy_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        rom_data_a <= rom_a[rom_addr_a];
        rom_data_b <= rom_b[rom_addr_b];
    end

    assign o_note  = sel ? note_b       : note_a;
    assign o_addr  = sel ? rom_addr_b   : rom_addr_a;
    assign o_on    = sel ? note_on_b    : note_on_a;
    assign o_start = sel ? note_start_b : note_start_a;
    assign o_done  = sel ? song_done_b  : song_done_a;
    assign o_busy  = sel ? busy_b       : busy_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: inputs set before this call are seen by the next posedge; outputs sampled at negedge.
    task automatic clk1();
        @(negedge clock);
        if (o_start === 1'b1) starts++;
        if (o_done === 1'b1) dones++;
    endtask

    task automatic ticks(input int n, input int gap);
        for (int k = 0; k < n; k++) begin
            beat_tick = 1'b1;
            clk1();
            beat_tick = 1'b0;
            repeat (gap - 1) clk1();
        end
    endtask

    function automatic int ent_note(input int i);
        logic [8:0] w;
        w = sel ? rom_b[i] : rom_a[i];
        return int'(w[8:4]);
    endfunction

    function automatic int ent_beats(input int i);
        logic [8:0] w;
        w = sel ? rom_b[i] : rom_a[i];
        return (w[3:0] == 4'd0) ? 1 : int'(w[3:0]);
    endfunction

    task automatic set_play(input logic v);
        if (sel) play_b = v;
        else     play_a = v;
    endtask

    // From IDLE: play rise must give note_start exactly three clocks later, on entry 0.
    task automatic start_play();
        int s0;
        s0 = starts;
        set_play(1'b1);
        clk1();
        clk1();
        chk("latency_early", {31'd0, o_start}, 32'd0);
        clk1();
        chk("latency_start", {31'd0, o_start}, 32'd1);
        chk("latency_count", starts, s0 + 1);
        chk("first_addr", o_addr, 32'd0);
    endtask

    // Play `count` entries starting at entry `first`; called right after that entry's note_start.
    task automatic run_entries(input int first, input int count, input int len, input bit loop,
                               input int gap);
        int  idx, nb, en, s0, d0, nxt;
        bit  last;
        idx = first;
        for (int k = 0; k < count; k++) begin
            en = ent_note(idx);
            nb = ent_beats(idx);
            chk("entry_note", o_note, en);
            chk("entry_gate", {31'd0, o_on}, (en != 0) ? 32'd1 : 32'd0);
            chk("entry_busy", {31'd0, o_busy}, 32'd1);
            s0 = starts;
            d0 = dones;
            if (nb > 1) ticks(nb - 1, gap);
            chk("hold_starts", starts, s0);
            chk("hold_note", o_note, en);
            beat_tick = 1'b1;
            clk1();
            beat_tick = 1'b0;
            chk("gap_gate_off", {31'd0, o_on}, 32'd0);
            last = (idx == len - 1);
            if (last && !loop) begin
                chk("end_done_pulse", dones, d0 + 1);
                chk("end_busy", {31'd0, o_busy}, 32'd1);
                repeat (4) clk1();
                chk("end_no_start", starts, s0);
                chk("end_note_held", o_note, en);
                chk("end_done_once", dones, d0 + 1);
                return;
            end
            nxt = last ? 0 : idx + 1;
            chk("next_addr", o_addr, nxt);
            chk("wrap_done_pulse", dones, d0 + (last ? 1 : 0));
            clk1();
            clk1();
            chk("next_start", starts, s0 + 1);
            chk("next_busy", {31'd0, o_busy}, 32'd1);
            repeat (gap - 3) clk1();
            idx = nxt;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_note"}, o_note, 32'd0);
        chk({tag, "_gate"}, {31'd0, o_on}, 32'd0);
        chk({tag, "_start"}, {31'd0, o_start}, 32'd0);
        chk({tag, "_done"}, {31'd0, o_done}, 32'd0);
        chk({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
        chk({tag, "_addr"}, o_addr, 32'd0);
    endtask

    initial begin
        int gap, s0, d0;
        reset = 1'b1;
        play_a = 1'b0;
        play_b = 1'b0;
        stop = 1'b0;
        beat_tick = 1'b0;
        for (int i = 0; i < 64; i++) begin
            rom_a[i] = 9'd0;
            rom_b[i] = 9'd0;
        end
        rom_a[0] = {5'd7, 4'd2};
        rom_a[1] = {5'd0, 4'd1};
        rom_a[2] = {5'd12, 4'd3};
        rom_b[0] = {5'd5, 4'd0};
        rom_b[1] = {5'd9, 4'd2};

        repeat (3) clk1();
        sel = 1'b0;
        chk_reset_outputs("rst_a");
        sel = 1'b1;
        chk_reset_outputs("rst_b");
        reset = 1'b0;
        clk1();

        // Basic three-entry song, tick every 10 clocks, ends in DONE.
        sel = 1'b0;
        start_play();
        run_entries(0, 3, 3, 1'b0, 10);
        set_play(1'b0);
        clk1();
        chk("done_to_idle_busy", {31'd0, o_busy}, 32'd0);
        chk("done_to_idle_addr", o_addr, 32'd0);

        // Looping instance: zero-duration entry, wrap with song_done, twice around.
        sel = 1'b1;
        start_play();
        run_entries(0, 5, 2, 1'b1, 8);
        stop = 1'b1;
        set_play(1'b0);
        clk1();
        stop = 1'b0;
        chk("loop_stop_busy", {31'd0, o_busy}, 32'd0);

        // Random ROM contents and tick spacing on both instances.
        for (int r = 0; r < 4; r++) begin
            sel = 1'b0;
            for (int i = 0; i < 3; i++)
                rom_a[i] = {5'($urandom_range(0, 31)), 4'($urandom_range(0, 15))};
            gap = $urandom_range(4, 12);
            start_play();
            run_entries(0, 3, 3, 1'b0, gap);
            set_play(1'b0);
            clk1();
            chk("rand_idle_busy", {31'd0, o_busy}, 32'd0);
        end
        for (int r = 0; r < 2; r++) begin
            sel = 1'b1;
            for (int i = 0; i < 2; i++)
                rom_b[i] = {5'($urandom_range(0, 31)), 4'($urandom_range(0, 15))};
            gap = $urandom_range(4, 12);
            start_play();
            run_entries(0, 3, 2, 1'b1, gap);
            stop = 1'b1;
            set_play(1'b0);
            clk1();
            stop = 1'b0;
            chk("rand_loop_stop_busy", {31'd0, o_busy}, 32'd0);
        end

        // Pause during a 4-beat entry: ticks while paused are ignored, no refetch on resume.
        sel = 1'b0;
        rom_a[0] = {5'd3, 4'd4};
        rom_a[1] = {5'd6, 4'd1};
        start_play();
        s0 = starts;
        ticks(1, 6);
        set_play(1'b0);
        clk1();
        chk("pause_gate_off", {31'd0, o_on}, 32'd0);
        ticks(3, 16);
        chk("pause_gate_still_off", {31'd0, o_on}, 32'd0);
        chk("pause_busy", {31'd0, o_busy}, 32'd1);
        chk("pause_note_held", o_note, 32'd3);
        set_play(1'b1);
        clk1();
        chk("resume_gate_on", {31'd0, o_on}, 32'd1);
        ticks(2, 6);
        chk("resume_no_start", starts, s0);
        chk("resume_note", o_note, 32'd3);
        beat_tick = 1'b1;
        clk1();
        beat_tick = 1'b0;
        chk("resume_gap_off", {31'd0, o_on}, 32'd0);
        clk1();
        clk1();
        chk("resume_advance", starts, s0 + 1);
        chk("resume_next_note", o_note, 32'd6);
        stop = 1'b1;
        set_play(1'b0);
        clk1();
        stop = 1'b0;

        // stop together with the song's final tick: rewind, no song_done.
        rom_a[0] = {5'd7, 4'd2};
        rom_a[1] = {5'd0, 4'd1};
        rom_a[2] = {5'd12, 4'd3};
        start_play();
        run_entries(0, 2, 3, 1'b0, 6);
        ticks(2, 6);
        d0 = dones;
        stop = 1'b1;
        beat_tick = 1'b1;
        set_play(1'b0);
        clk1();
        stop = 1'b0;
        beat_tick = 1'b0;
        chk_reset_outputs("stop_tick");
        repeat (3) clk1();
        chk("stop_no_done", dones, d0);
        chk("stop_stays_idle", {31'd0, o_busy}, 32'd0);

        // Reset while three beats remain, then replay restarts at entry 0.
        rom_a[0] = {5'd3, 4'd4};
        start_play();
        ticks(1, 6);
        reset = 1'b1;
        clk1();
        chk_reset_outputs("rst_mid");
        reset = 1'b0;
        s0 = starts;
        clk1();
        clk1();
        chk("replay_early", {31'd0, o_start}, 32'd0);
        clk1();
        chk("replay_start", starts, s0 + 1);
        chk("replay_note", o_note, 32'd3);
        chk("replay_addr", o_addr, 32'd0);
        stop = 1'b1;
        set_play(1'b0);
        clk1();
        stop = 1'b0;
        clk1();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
